// File: rtl/ysyx_22041071_axi_burst_rd.sv
// AXI4 read master: one request -> one AR -> R beats gathered into a line -> one response.
// Latency: accept->AR 1 cycle, last beat->response 1 cycle; single outstanding, stalls on ar/r/rsp handshakes.
module ysyx_22041071_axi_burst_rd #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 64,
  parameter int ID_W      = 4,
  parameter int MAX_BEATS = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [ADDR_W-1:0]           req_addr_i,
  input  logic [7:0]                  req_len_i,
  input  logic [2:0]                  req_size_i,
  input  logic [ID_W-1:0]             req_id_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [MAX_BEATS*DATA_W-1:0] rsp_data_o,
  output logic [1:0]                  rsp_resp_o,
  output logic                        rsp_err_o,
  output logic                        ar_valid_o,
  input  logic                        ar_ready_i,
  output logic [ID_W-1:0]             ar_id_o,
  output logic [ADDR_W-1:0]           ar_addr_o,
  output logic [7:0]                  ar_len_o,
  output logic [2:0]                  ar_size_o,
  output logic [1:0]                  ar_burst_o,
  output logic [2:0]                  ar_prot_o,
  output logic [3:0]                  ar_cache_o,
  output logic                        ar_lock_o,
  input  logic                        r_valid_i,
  output logic                        r_ready_o,
  input  logic [DATA_W-1:0]           r_data_i,
  input  logic [1:0]                  r_resp_i,
  input  logic                        r_last_i,
  input  logic [ID_W-1:0]             r_id_i
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int CNT_W = 9;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]                  state_q, state_d;
  logic [ID_W-1:0]             ar_id_q, ar_id_d;
  logic [ADDR_W-1:0]           ar_addr_q, ar_addr_d;
  logic [7:0]                  ar_len_q, ar_len_d;
  logic [2:0]                  ar_size_q, ar_size_d;
  logic [OFF_W-1:0]            off_q, off_d;
  logic [MAX_BEATS*DATA_W-1:0] line_q, line_d;
  logic [1:0]                  resp_q, resp_d;
  logic                        err_q, err_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  logic [DATA_W-1:0] fmt_mask;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] beat_dat;

  // Single-beat reads are right-aligned and trimmed to the requested size.
  always_comb begin
    fmt_mask = '0;
    for (int i = 0; i < DATA_W; i++) begin
      fmt_mask[i] = (32'(i) < (32'd8 << ar_size_q));
    end
  end

  assign shifted  = r_data_i >> {off_q, 3'b000};
  assign beat_dat = (ar_len_q == 8'd0) ? (shifted & fmt_mask) : r_data_i;

  always_comb begin
    state_d   = state_q;
    ar_id_d   = ar_id_q;
    ar_addr_d = ar_addr_q;
    ar_len_d  = ar_len_q;
    ar_size_d = ar_size_q;
    off_d     = off_q;
    line_d    = line_q;
    resp_d    = resp_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          state_d  = S_ADDR;
          ar_id_d  = req_id_i;
          ar_len_d = req_len_i;
          off_d    = req_addr_i[OFF_W-1:0];
          if (req_len_i == 8'd0) begin
            ar_addr_d = req_addr_i & ({ADDR_W{1'b1}} << req_size_i);
            ar_size_d = req_size_i;
          end else begin
            ar_addr_d = req_addr_i & ({ADDR_W{1'b1}} << OFF_W);
            ar_size_d = 3'(OFF_W);
          end
          line_d = '0;
          resp_d = 2'd0;
          err_d  = 1'b0;
          cnt_d  = '0;
        end
      end
      S_ADDR: begin
        if (ar_ready_i) state_d = S_DATA;
      end
      S_DATA: begin
        if (r_valid_i) begin
          if (cnt_q < CNT_W'(MAX_BEATS)) begin
            for (int k = 0; k < MAX_BEATS; k++) begin
              if (cnt_q == CNT_W'(k)) line_d[k*DATA_W +: DATA_W] = beat_dat;
            end
          end else begin
            err_d = 1'b1;
          end
          if (r_resp_i > resp_q) resp_d = r_resp_i;
          if (r_id_i != ar_id_q) err_d = 1'b1;
          // Count/RLAST disagreement is flagged, but only RLAST ends the burst.
          if (r_last_i != (cnt_q == {1'b0, ar_len_q})) err_d = 1'b1;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
          if (r_last_i) state_d = S_DONE;
        end
      end
      default: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ar_id_q   <= '0;
      ar_addr_q <= '0;
      ar_len_q  <= '0;
      ar_size_q <= '0;
      off_q     <= '0;
      line_q    <= '0;
      resp_q    <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ar_id_q   <= ar_id_d;
      ar_addr_q <= ar_addr_d;
      ar_len_q  <= ar_len_d;
      ar_size_q <= ar_size_d;
      off_q     <= off_d;
      line_q    <= line_d;
      resp_q    <= resp_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign ar_valid_o  = (state_q == S_ADDR);
  assign r_ready_o   = (state_q == S_DATA);
  assign rsp_valid_o = (state_q == S_DONE);
  assign rsp_data_o  = line_q;
  assign rsp_resp_o  = resp_q;
  assign rsp_err_o   = err_q;
  assign ar_id_o     = ar_id_q;
  assign ar_addr_o   = ar_addr_q;
  assign ar_len_o    = ar_len_q;
  assign ar_size_o   = ar_size_q;
  assign ar_burst_o  = 2'b01;
  assign ar_prot_o   = 3'b000;
  assign ar_cache_o  = 4'b0000;
  assign ar_lock_o   = 1'b0;

endmodule

// File: tb/tb_ysyx_22041071_axi_burst_rd.sv
// Bench for the AXI burst read master: slave BFM driven from tasks, expectations from a line-level model.
module tb_ysyx_22041071_axi_burst_rd;
  localparam int DW = 64, AW = 64, IW = 4, MB = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic              req_valid = 0, req_ready;
  logic [AW-1:0]     req_addr = '0;
  logic [7:0]        req_len = '0;
  logic [2:0]        req_size = '0;
  logic [IW-1:0]     req_id = '0;
  logic              rsp_valid, rsp_ready = 0;
  logic [MB*DW-1:0]  rsp_data;
  logic [1:0]        rsp_resp;
  logic              rsp_err;
  logic              ar_valid, ar_ready = 0;
  logic [IW-1:0]     ar_id;
  logic [AW-1:0]     ar_addr;
  logic [7:0]        ar_len;
  logic [2:0]        ar_size;
  logic [1:0]        ar_burst;
  logic [2:0]        ar_prot;
  logic [3:0]        ar_cache;
  logic              ar_lock;
  logic              r_valid = 0, r_ready;
  logic [DW-1:0]     r_data = '0;
  logic [1:0]        r_resp = '0;
  logic              r_last = 0;
  logic [IW-1:0]     r_id = '0;

  ysyx_22041071_axi_burst_rd #(.DATA_W(DW), .ADDR_W(AW), .ID_W(IW), .MAX_BEATS(MB)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_len_i(req_len), .req_size_i(req_size), .req_id_i(req_id),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_resp_o(rsp_resp), .rsp_err_o(rsp_err),
    .ar_valid_o(ar_valid), .ar_ready_i(ar_ready), .ar_id_o(ar_id), .ar_addr_o(ar_addr),
    .ar_len_o(ar_len), .ar_size_o(ar_size), .ar_burst_o(ar_burst), .ar_prot_o(ar_prot),
    .ar_cache_o(ar_cache), .ar_lock_o(ar_lock),
    .r_valid_i(r_valid), .r_ready_o(r_ready), .r_data_i(r_data), .r_resp_i(r_resp),
    .r_last_i(r_last), .r_id_i(r_id)
  );

  int total = 0, bad = 0;

  // Slave stimulus for one transaction: beats, their resp/id, and stall knobs.
  logic [63:0] bd [0:7];
  logic [1:0]  br [0:7];
  logic [3:0]  bid[0:7];
  int nb, ar_wait, rsp_wait, gap_en;

  // Observations of the last transaction.
  logic         o_ar_vis, o_ar_stable, o_rsp_now, o_rsp_stable, o_busy_rdy, o_timeout, o_req_after;
  logic [63:0]  o_ar_addr;
  logic [2:0]   o_ar_size;
  logic [7:0]   o_ar_len;
  logic [3:0]   o_ar_id;
  logic [255:0] o_rsp_data;
  logic [1:0]   o_rsp_resp;
  logic         o_rsp_err;

  // Expected response from the line-level rules.
  logic [255:0] e_data;
  logic [1:0]   e_resp;
  logic         e_err;

  function automatic void model(input logic [63:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [3:0] id);
    logic [63:0] v;
    int nbits;
    e_data = '0;
    e_resp = 2'd0;
    e_err  = 1'b0;
    if (len == 8'd0) begin
      v = bd[0] >> (8 * int'(addr[2:0]));
      nbits = 8 << size;
      if (nbits < 64) v = v & ((64'd1 << nbits) - 64'd1);
      e_data[63:0] = v;
    end else begin
      for (int k = 0; k < nb && k < MB; k++) e_data[k*64 +: 64] = bd[k];
    end
    for (int k = 0; k < nb; k++) begin
      if (br[k] > e_resp) e_resp = br[k];
      if (bid[k] != id) e_err = 1'b1;
    end
    if (nb - 1 != int'(len) || nb > MB) e_err = 1'b1;
  endfunction

  task automatic run_txn(input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [3:0] id);
    int g;
    o_timeout = 0; o_ar_stable = 1; o_rsp_stable = 1; o_busy_rdy = 0;
    @(negedge clk);
    req_valid = 1; req_addr = addr; req_len = len; req_size = size; req_id = id;
    @(negedge clk);
    req_valid = 0;
    o_ar_vis = ar_valid; o_ar_addr = ar_addr; o_ar_size = ar_size;
    o_ar_len = ar_len; o_ar_id = ar_id;
    for (int w = 0; w < ar_wait; w++) begin
      @(negedge clk);
      if (!ar_valid || ar_addr !== o_ar_addr || ar_size !== o_ar_size ||
          ar_len !== o_ar_len || ar_id !== o_ar_id) o_ar_stable = 0;
      if (req_ready) o_busy_rdy = 1;
    end
    ar_ready = 1;
    g = 0;
    while (!ar_valid && g < 50) begin @(negedge clk); g++; end
    if (g >= 50) o_timeout = 1;
    @(negedge clk);
    ar_ready = 0;
    for (int i = 0; i < nb; i++) begin
      if (gap_en != 0 && $urandom_range(0, 1) == 1) @(negedge clk);
      r_valid = 1; r_data = bd[i]; r_resp = br[i]; r_id = bid[i]; r_last = (i == nb - 1);
      g = 0;
      while (!r_ready && g < 50) begin @(negedge clk); g++; end
      if (g >= 50) o_timeout = 1;
      if (req_ready) o_busy_rdy = 1;
      @(negedge clk);
      r_valid = 0; r_last = 0;
    end
    o_rsp_now = rsp_valid; o_rsp_data = rsp_data; o_rsp_resp = rsp_resp; o_rsp_err = rsp_err;
    for (int w = 0; w < rsp_wait; w++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== o_rsp_data || rsp_resp !== o_rsp_resp ||
          rsp_err !== o_rsp_err) o_rsp_stable = 0;
      if (req_ready) o_busy_rdy = 1;
    end
    rsp_ready = 1;
    g = 0;
    while (!rsp_valid && g < 50) begin @(negedge clk); g++; end
    if (g >= 50) o_timeout = 1;
    @(negedge clk);
    rsp_ready = 0;
    o_req_after = req_ready;
  endtask

  task automatic test_reset;
    reset_n = 0;
    repeat (3) @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    total++; if ({ar_valid, r_ready, rsp_valid} !== 3'b000) begin bad++; $display("FAIL reset_valids got=%b want=000", {ar_valid, r_ready, rsp_valid}); end
    total++; if (rsp_data !== '0 || rsp_resp !== 2'd0 || rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp got=%h/%0d/%b want=0", rsp_data, rsp_resp, rsp_err); end
    total++; if (ar_addr !== '0 || ar_len !== 8'd0 || ar_size !== 3'd0 || ar_id !== 4'd0) begin bad++; $display("FAIL reset_ar_payload got=%h/%0d/%0d/%0d want=0", ar_addr, ar_len, ar_size, ar_id); end
    total++; if ({ar_burst, ar_prot, ar_cache, ar_lock} !== {2'b01, 3'd0, 4'd0, 1'b0}) begin bad++; $display("FAIL ar_consts got=%b want=01_000_0000_0", {ar_burst, ar_prot, ar_cache, ar_lock}); end
    reset_n = 1;
    @(negedge clk);
  endtask

  task automatic test_single;
    logic [63:0] a;
    logic [2:0]  s;
    nb = 1; ar_wait = 0; rsp_wait = 0; gap_en = 0;
    bd[0] = 64'h1122334455667788; br[0] = 2'd0; bid[0] = 4'd3;
    run_txn(64'h8000_0005, 8'd0, 3'd0, 4'd3);
    total++; if (o_rsp_data !== 256'h33) begin bad++; $display("FAIL single_data got=%h want=33", o_rsp_data); end
    total++; if (o_rsp_resp !== 2'd0 || o_rsp_err !== 1'b0) begin bad++; $display("FAIL single_status got=%0d/%b want=0/0", o_rsp_resp, o_rsp_err); end
    total++; if (o_ar_addr !== 64'h8000_0005 || o_ar_size !== 3'd0 || o_ar_len !== 8'd0) begin bad++; $display("FAIL single_ar got=%h/%0d/%0d want=80000005/0/0", o_ar_addr, o_ar_size, o_ar_len); end
    total++; if (o_ar_vis !== 1'b1 || o_rsp_now !== 1'b1 || o_timeout !== 1'b0) begin bad++; $display("FAIL single_latency got=ar%b rsp%b to%b want=1/1/0", o_ar_vis, o_rsp_now, o_timeout); end
    for (int t = 0; t < 8; t++) begin
      s = 3'($urandom_range(0, 3));
      a = {32'h8000_0000, $urandom} & ~((64'd1 << s) - 64'd1);
      bd[0] = {$urandom, $urandom}; br[0] = 2'($urandom_range(0, 3)); bid[0] = 4'(t);
      model(a, 8'd0, s, 4'(t));
      run_txn(a, 8'd0, s, 4'(t));
      total++; if (o_rsp_data !== e_data || o_rsp_resp !== e_resp || o_rsp_err !== e_err) begin bad++; $display("FAIL single_rand[%0d] got=%h/%0d/%b want=%h/%0d/%b", t, o_rsp_data, o_rsp_resp, o_rsp_err, e_data, e_resp, e_err); end
      total++; if (o_ar_addr !== a || o_ar_size !== s || o_ar_id !== 4'(t)) begin bad++; $display("FAIL single_rand_ar[%0d] got=%h/%0d/%0d want=%h/%0d/%0d", t, o_ar_addr, o_ar_size, o_ar_id, a, s, t); end
    end
  endtask

  task automatic test_burst;
    logic [63:0] a;
    logic [7:0]  l;
    nb = 4; ar_wait = 5; rsp_wait = 0; gap_en = 0;
    for (int k = 0; k < 4; k++) begin bd[k] = {$urandom, $urandom}; br[k] = 2'd0; bid[k] = 4'd2; end
    model(64'h8000_0018, 8'd3, 3'd0, 4'd2);
    run_txn(64'h8000_0018, 8'd3, 3'd0, 4'd2);
    total++; if (o_ar_addr !== 64'h8000_0018 || o_ar_size !== 3'd3 || o_ar_len !== 8'd3) begin bad++; $display("FAIL burst_ar got=%h/%0d/%0d want=80000018/3/3", o_ar_addr, o_ar_size, o_ar_len); end
    total++; if (o_ar_stable !== 1'b1 || o_busy_rdy !== 1'b0) begin bad++; $display("FAIL burst_ar_stall got=stable%b rdy%b want=1/0", o_ar_stable, o_busy_rdy); end
    total++; if (o_rsp_data !== {bd[3], bd[2], bd[1], bd[0]} || o_rsp_err !== 1'b0) begin bad++; $display("FAIL burst_data got=%h/%b want=%h/0", o_rsp_data, o_rsp_err, {bd[3], bd[2], bd[1], bd[0]}); end
    ar_wait = 0;
    for (int t = 0; t < 6; t++) begin
      l = 8'($urandom_range(1, 3)); nb = int'(l) + 1;
      a = {32'h8000_0000, $urandom};
      for (int k = 0; k < nb; k++) begin bd[k] = {$urandom, $urandom}; br[k] = 2'($urandom_range(0, 1)); bid[k] = 4'd9; end
      model(a, l, 3'($urandom_range(0, 7)), 4'd9);
      run_txn(a, l, 3'($urandom_range(0, 7)), 4'd9);
      total++; if (o_rsp_data !== e_data || o_rsp_resp !== e_resp || o_rsp_err !== e_err) begin bad++; $display("FAIL burst_rand[%0d] got=%h/%0d/%b want=%h/%0d/%b", t, o_rsp_data, o_rsp_resp, o_rsp_err, e_data, e_resp, e_err); end
      total++; if (o_ar_addr !== {a[63:3], 3'b000} || o_ar_size !== 3'd3 || o_ar_len !== l) begin bad++; $display("FAIL burst_rand_ar[%0d] got=%h/%0d/%0d want=%h/3/%0d", t, o_ar_addr, o_ar_size, o_ar_len, {a[63:3], 3'b000}, l); end
    end
  endtask

  task automatic test_resp_merge;
    nb = 4; ar_wait = 0; rsp_wait = 0; gap_en = 0;
    for (int k = 0; k < 4; k++) begin bd[k] = {$urandom, $urandom}; bid[k] = 4'd1; end
    br[0] = 2'd0; br[1] = 2'd2; br[2] = 2'd0; br[3] = 2'd0;
    run_txn(64'h8000_1000, 8'd3, 3'd3, 4'd1);
    total++; if (o_rsp_resp !== 2'd2) begin bad++; $display("FAIL resp_merge got=%0d want=2", o_rsp_resp); end
    total++; if (o_rsp_data !== {bd[3], bd[2], bd[1], bd[0]} || o_rsp_err !== 1'b0) begin bad++; $display("FAIL resp_merge_data got=%h/%b want=%h/0", o_rsp_data, o_rsp_err, {bd[3], bd[2], bd[1], bd[0]}); end
  endtask

  task automatic test_protocol;
    ar_wait = 0; rsp_wait = 0; gap_en = 0;
    // Early RLAST on the second beat of a four-beat burst.
    nb = 2;
    for (int k = 0; k < 2; k++) begin bd[k] = {$urandom, $urandom}; br[k] = 2'd0; bid[k] = 4'd4; end
    model(64'h8000_2000, 8'd3, 3'd3, 4'd4);
    run_txn(64'h8000_2000, 8'd3, 3'd3, 4'd4);
    total++; if (o_rsp_now !== 1'b1 || o_rsp_err !== 1'b1 || o_timeout !== 1'b0) begin bad++; $display("FAIL early_last got=rsp%b err%b to%b want=1/1/0", o_rsp_now, o_rsp_err, o_timeout); end
    total++; if (o_rsp_data !== e_data) begin bad++; $display("FAIL early_last_data got=%h want=%h", o_rsp_data, e_data); end
    // Wrong RID.
    nb = 1; bd[0] = {$urandom, $urandom}; br[0] = 2'd0; bid[0] = 4'd5;
    run_txn(64'h8000_3000, 8'd0, 3'd3, 4'd3);
    total++; if (o_rsp_err !== 1'b1) begin bad++; $display("FAIL id_mismatch got=%b want=1", o_rsp_err); end
    // Missing RLAST at the expected beat; slave finishes one beat late.
    nb = 3;
    for (int k = 0; k < 3; k++) begin bd[k] = {$urandom, $urandom}; br[k] = 2'd0; bid[k] = 4'd6; end
    model(64'h8000_4000, 8'd1, 3'd3, 4'd6);
    run_txn(64'h8000_4000, 8'd1, 3'd3, 4'd6);
    total++; if (o_rsp_err !== 1'b1 || o_rsp_data !== e_data || o_timeout !== 1'b0) begin bad++; $display("FAIL late_last got=%h/%b want=%h/1", o_rsp_data, o_rsp_err, e_data); end
    // Burst longer than the line buffer: excess beats dropped.
    nb = 6;
    for (int k = 0; k < 6; k++) begin bd[k] = {$urandom, $urandom}; br[k] = 2'd0; bid[k] = 4'd7; end
    model(64'h8000_5000, 8'd5, 3'd3, 4'd7);
    run_txn(64'h8000_5000, 8'd5, 3'd3, 4'd7);
    total++; if (o_rsp_err !== 1'b1 || o_rsp_data !== e_data) begin bad++; $display("FAIL overflow got=%h/%b want=%h/1", o_rsp_data, o_rsp_err, e_data); end
  endtask

  task automatic test_backpressure;
    nb = 4; ar_wait = 2; rsp_wait = 3; gap_en = 1;
    for (int k = 0; k < 4; k++) begin bd[k] = {$urandom, $urandom}; br[k] = 2'($urandom_range(0, 3)); bid[k] = 4'd8; end
    model(64'h8000_6008, 8'd3, 3'd3, 4'd8);
    run_txn(64'h8000_6008, 8'd3, 3'd3, 4'd8);
    total++; if (o_rsp_stable !== 1'b1 || o_busy_rdy !== 1'b0) begin bad++; $display("FAIL rsp_hold got=stable%b rdy%b want=1/0", o_rsp_stable, o_busy_rdy); end
    total++; if (o_rsp_data !== e_data || o_rsp_resp !== e_resp || o_rsp_err !== e_err) begin bad++; $display("FAIL bp_data got=%h/%0d/%b want=%h/%0d/%b", o_rsp_data, o_rsp_resp, o_rsp_err, e_data, e_resp, e_err); end
    total++; if (o_req_after !== 1'b1 || o_timeout !== 1'b0) begin bad++; $display("FAIL bp_release got=rdy%b to%b want=1/0", o_req_after, o_timeout); end
  endtask

  task automatic test_reset_mid;
    logic saw_ar;
    @(negedge clk);
    req_valid = 1; req_addr = 64'h8000_7000; req_len = 8'd3; req_size = 3'd3; req_id = 4'd2;
    @(negedge clk);
    req_valid = 0; ar_ready = 1;
    @(negedge clk);
    ar_ready = 0; r_valid = 1; r_data = 64'hDEAD_BEEF; r_id = 4'd2; r_resp = 2'd0; r_last = 0;
    @(negedge clk);
    r_valid = 0;
    total++; if (r_ready !== 1'b1) begin bad++; $display("FAIL mid_in_data got=%b want=1", r_ready); end
    reset_n = 0;
    @(negedge clk);
    total++; if ({req_ready, r_ready, rsp_valid} !== 3'b100) begin bad++; $display("FAIL mid_reset got=%b want=100", {req_ready, r_ready, rsp_valid}); end
    reset_n = 1;
    saw_ar = 0;
    repeat (4) begin @(negedge clk); if (ar_valid || r_ready || rsp_valid) saw_ar = 1; end
    total++; if (saw_ar !== 1'b0) begin bad++; $display("FAIL mid_quiet got=%b want=0", saw_ar); end
    nb = 1; ar_wait = 0; rsp_wait = 0; gap_en = 0;
    bd[0] = 64'h0102030405060708; br[0] = 2'd1; bid[0] = 4'd1;
    run_txn(64'h8000_8004, 8'd0, 3'd2, 4'd1);
    total++; if (o_rsp_data !== 256'h01020304 || o_rsp_resp !== 2'd1 || o_rsp_err !== 1'b0) begin bad++; $display("FAIL after_reset got=%h/%0d/%b want=01020304/1/0", o_rsp_data, o_rsp_resp, o_rsp_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_resp_merge();
    test_protocol();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
